// File: rtl/ble_cmd_ctrl.sv
// rtl/ble_cmd_ctrl.sv - byte-framed LED command parser with checksum and inter-byte timeout
module ble_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_byte_valid,
  input  logic [7:0] in_byte,
  output logic [3:0] out_led,
  output logic       out_cmd_ok,
  output logic       out_cmd_err,
  output logic       out_busy,
  output logic [7:0] out_err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GET_CMD = 2'd1,
    S_GET_ARG = 2'd2,
    S_GET_CHK = 2'd3
  } state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [7:0]  arg_q, arg_d;
  logic [3:0]  led_q, led_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'h0000;
      cmd_q     <= 8'h00;
      arg_q     <= 8'h00;
      led_q     <= 4'b0000;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      arg_q     <= arg_d;
      led_q     <= led_d;
      ok_q      <= ok_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    led_d     = led_q;
    ok_d      = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_byte_valid && (in_byte == SOF_BYTE)) begin
          state_d = S_GET_CMD;
        end
      end
      S_GET_CMD: begin
        if (in_byte_valid) begin
          cmd_d   = in_byte;
          state_d = S_GET_ARG;
        end
      end
      S_GET_ARG: begin
        if (in_byte_valid) begin
          arg_d   = in_byte;
          state_d = S_GET_CHK;
        end
      end
      S_GET_CHK: begin
        if (in_byte_valid) begin
          state_d = S_IDLE;
          if (in_byte == (cmd_q ^ arg_q)) begin
            case (cmd_q)
              8'h01: begin led_d = arg_q[3:0];         ok_d = 1'b1; end
              8'h02: begin led_d = led_q ^ arg_q[3:0]; ok_d = 1'b1; end
              8'h03: begin led_d = 4'b0000;            ok_d = 1'b1; end
              default: err_d = 1'b1;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A byte on the threshold cycle takes priority over the timeout abort.
    if (state_q == S_IDLE) begin
      cnt_d = 16'h0000;
    end else if (in_byte_valid) begin
      cnt_d = 16'h0000;
    end else if (cnt_q == TO_LAST) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      cnt_d   = 16'h0000;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end

    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  assign out_led     = led_q;
  assign out_cmd_ok  = ok_q;
  assign out_cmd_err = err_q;
  assign out_busy    = (state_q != S_IDLE);
  assign out_err_cnt = err_cnt_q;

endmodule
